sc_pack_fifo: RTL and testbench
===============================

# sc_pack_fifo

Single-clock, width-converting (packing) FIFO. It accepts narrow `DATA_IN_W` words and emits `DATA_OUT_W = DATA_IN_W*RATIO` words, with an arbitrary integer `RATIO`, an optional show-ahead read mode, a programmable almost-full flag, partial-word flush, and sticky error flags. It sits between the camera pixel capture and the USB3 slave-FIFO writer, which run on the same clock. It replaces the vendor mixed-width FIFO on those paths.

## Interface
- `DATA_IN_W`, 8: input lane width.
- `RATIO`, 2: input lanes per output word, ≥1. `DATA_OUT_W` is a localparam equal to `DATA_IN_W*RATIO`.
- `ADDR_W`, 10: storage depth is `DEPTH = 2**ADDR_W` output words.
- `SHOWAHEAD`, 0: 0 = registered normal read; 1 = show-ahead (head word visible on `data_out`).
- `AFULL_TH`, `DEPTH-16`: `wr_afull` is high when the word count is ≥ this value.
- `LSB_FIRST`, 1: 1 = the first lane written lands in bits `[DATA_IN_W-1:0]`; 0 = it lands in the MSBs.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `wrreq` in 1: write one lane.
- `data_in` in `DATA_IN_W`: lane data.
- `flush` in 1: pulse; push the partial word.
- `wrfull` out 1: storage full; lanes are refused.
- `wr_afull` out 1: count ≥ `AFULL_TH`.
- `rdreq` in 1: read or pop one word.
- `data_out` out `DATA_OUT_W`: read data.
- `rdempty` out 1: no word available.
- `rdusedw` out `ADDR_W+1`: words held, 0..`DEPTH`.
- `overflow` out 1: sticky; set by `wrreq` while `wrfull`.
- `underflow` out 1: sticky; set by `rdreq` while `rdempty`.
- `clr_err` in 1: clears both sticky flags.

## Operation
- **Packing**
  - The packer holds a lane counter `lane` (0..`RATIO-1`) and `RATIO-1` lane registers.
  - An accepted write (`wrreq && !wrfull`) with `lane < RATIO-1` stores the lane and increments `lane`.
  - An accepted write with `lane == RATIO-1` assembles `{data_in, held lanes}` in `LSB_FIRST` order, writes it to storage on the same edge, and sets `lane` to 0.
- **Flush**
  - `flush` sets `flush_pend`.
  - While `flush_pend` is set, `lane > 0`, and `!wrfull`, the partial word is pushed with its unfilled lanes zeroed. `lane` and `flush_pend` then clear.
  - If `lane == 0`, `flush_pend` simply clears.
  - If `flush` coincides with an accepted write, the written lane is included before padding. If that write completes the word, no extra word is pushed.
  - While `flush_pend` is set, `wrfull` is forced high so no new lanes mix in.
- **Read, `SHOWAHEAD=0`**
  - `rdreq && !rdempty` pops one word. The word appears on `data_out` one cycle later and is then held.
- **Read, `SHOWAHEAD=1`**
  - A prefetch register presents the head word while `!rdempty`.
  - `rdreq && !rdempty` pops it, and the next word is shown the cycle after.
- **Counting**
  - `rdusedw` counts complete words in RAM plus the prefetch register. Partial lanes are not counted.
  - A simultaneous push and pop leaves the count unchanged.
  - `wrfull` = (`rdusedw == DEPTH`) or `flush_pend`.
  - `rdempty` = (no readable word).
  - The pointers wrap modulo `DEPTH`.
- **Errors**
  - A refused write or read changes no state other than the sticky flag it sets.
  - `clr_err` has priority over a set event in the same cycle.
- **Reset** (synchronous, `rst` high), on the next edge:
  - `lane`, pointers, count and `flush_pend` go to 0.
  - `data_out` goes to 0.
  - `rdempty` goes to 1; `wrfull`, `wr_afull`, `overflow` and `underflow` go to 0.
  - Any partial or in-flight word is discarded.

## Timing
- All outputs are derived from registers. No combinational path runs from `wrreq`/`rdreq` to `wrfull`/`rdempty`.
- Push into an empty FIFO to `rdempty` low:
  - `SHOWAHEAD=0`: 1 cycle.
  - `SHOWAHEAD=1`: 2 cycles (RAM read plus prefetch load).
- `rdusedw` and `wr_afull` update 1 cycle after the push or pop edge.
- When full, a same-cycle pop and write refuses the write. `wrfull` falls on the next cycle.
- Throughput: one lane per cycle in and one word per cycle out, sustained.

## Structure
- A shared package `fifo_pkg` holds:
  - the lane-order constants `LANE_LSB_FIRST`/`LANE_MSB_FIRST`;
  - the read-mode constants `RD_NORMAL`/`RD_SHOWAHEAD`;
  - a `clog2` helper function.
- Sub-module `sc_sdp_ram`: an inferred simple dual-port RAM (`DEPTH` × `DATA_OUT_W`) with a 1-cycle registered read.
- The packer, flush logic, pointers, counter and prefetch register stay in `sc_pack_fifo`.

## Test plan
- `RATIO=2`, `LSB_FIRST=1`: write 0x11, 0x22, then read. Required: `data_out` = 0x2211; `rdusedw` goes 0→1→0.
- `RATIO=4`: write 0xA1, 0xA2, 0xA3, then pulse `flush`. Required: one word 0x00A3A2A1; `wrfull` high for exactly the cycles `flush_pend` is set.
- `ADDR_W=3`: write until `wrfull`, one extra write, then pop once while writing. Required: `rdusedw` = 8, `overflow` = 1, the extra lane is dropped, then `rdusedw` returns to 8 with no data loss.
- `SHOWAHEAD=1`: push 3 words, then pop back-to-back. Required: head visible 2 cycles after the first push; words appear in order, one per cycle; `rdempty` is high after the third pop.
- `rdreq` on an empty FIFO, then `clr_err`. Required: `underflow` = 1, then 0; pointers unchanged.
- Assert `rst` mid-packet with `lane = 1` and 5 words stored. Required: the next edge shows `rdempty` = 1, `rdusedw` = 0, `data_out` = 0, and the following lane starts a fresh word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Lane-order and read-mode selectors, plus a constant-foldable ceil(log2).
package fifo_pkg;

  localparam int LANE_MSB_FIRST = 0;
  localparam int LANE_LSB_FIRST = 1;

  localparam int RD_NORMAL    = 0;
  localparam int RD_SHOWAHEAD = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sc_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read data holds between reads and clears on reset.
module sc_sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sc_pack_fifo.sv
// Width-converting packing FIFO: RATIO narrow lanes in, one wide word out.
// Supports partial-word flush, optional show-ahead read and sticky error flags.
module sc_pack_fifo
  import fifo_pkg::*;
#(
  parameter int  DATA_IN_W  = 8,
  parameter int  RATIO      = 2,
  parameter int  ADDR_W     = 10,
  parameter int  SHOWAHEAD  = RD_NORMAL,
  parameter int  AFULL_TH   = (2**ADDR_W) - 16,
  parameter int  LSB_FIRST  = LANE_LSB_FIRST,
  localparam int DATA_OUT_W = DATA_IN_W*RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrreq,
  input  logic [DATA_IN_W-1:0]  data_in,
  input  logic                  flush,
  output logic                  wrfull,
  output logic                  wr_afull,
  input  logic                  rdreq,
  output logic [DATA_OUT_W-1:0] data_out,
  output logic                  rdempty,
  output logic [ADDR_W:0]       rdusedw,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam int                LANE_W    = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO-1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W+1)'(AFULL_TH);

  logic [LANE_W-1:0]                lane;
  logic [RATIO-1:0][DATA_IN_W-1:0]  hold;
  logic [RATIO-1:0][DATA_IN_W-1:0]  slot;
  logic                             flush_pend;
  logic [ADDR_W:0]                  wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic [DATA_OUT_W-1:0]            word, ram_rdata, pf_q;
  logic                             pf_vld, rd_pend;
  logic                             ram_full, wr_acc, word_done, flush_push, push, pop;
  logic                             pf_load, ram_re;

  assign ram_full   = (cnt == DEPTH_CNT);
  assign wrfull     = ram_full || flush_pend;
  assign rdempty    = (SHOWAHEAD == RD_SHOWAHEAD) ? !pf_vld : (cnt == '0);
  assign wr_acc     = wrreq && !wrfull;
  assign word_done  = wr_acc && (lane == LAST_LANE);
  assign flush_push = flush_pend && (lane != '0) && !ram_full;
  assign push       = word_done || flush_push;
  assign pop        = rdreq && !rdempty;

  // Show-ahead pipeline: RAM read register feeds the prefetch register; a new
  // RAM read is only issued when the read register is free or being drained.
  assign pf_load  = rd_pend && (!pf_vld || pop);
  assign ram_re   = (SHOWAHEAD == RD_SHOWAHEAD) ?
                    ((rd_ptr != wr_ptr) && (!rd_pend || pf_load)) : pop;
  assign data_out = (SHOWAHEAD == RD_SHOWAHEAD) ? pf_q : ram_rdata;
  assign rdusedw  = cnt;

  // Lanes below the counter come from the holding registers, the current lane
  // from data_in on a write, everything above is zero padding.
  always_comb begin
    slot = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) < lane)                 slot[i] = hold[i];
      else if (LANE_W'(i) == lane && wr_acc) slot[i] = data_in;
    end
    word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LSB_FIRST == LANE_LSB_FIRST) word[i*DATA_IN_W +: DATA_IN_W] = slot[i];
      else                             word[(RATIO-1-i)*DATA_IN_W +: DATA_IN_W] = slot[i];
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 1'b1;
    else if (pop && !push) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !word_done)
      for (int i = 0; i < RATIO; i++)
        if (lane == LANE_W'(i)) hold[i] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      wr_afull   <= 1'b0;
      pf_vld     <= 1'b0;
      rd_pend    <= 1'b0;
      pf_q       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push)        lane <= '0;
      else if (wr_acc) lane <= lane + 1'b1;

      if (flush)                                         flush_pend <= 1'b1;
      else if (flush_pend && (lane == '0 || flush_push)) flush_pend <= 1'b0;

      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt_nxt;
      wr_afull <= (cnt_nxt >= AFULL_CNT);

      if (ram_re)       rd_pend <= 1'b1;
      else if (pf_load) rd_pend <= 1'b0;
      if (pf_load)      pf_vld  <= 1'b1;
      else if (pop)     pf_vld  <= 1'b0;
      if (pf_load)      pf_q    <= ram_rdata;

      if (clr_err)              overflow  <= 1'b0;
      else if (wrreq && wrfull) overflow  <= 1'b1;
      if (clr_err)              underflow <= 1'b0;
      else if (rdreq && rdempty) underflow <= 1'b1;
    end
  end

  sc_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_OUT_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (word),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sc_pack_fifo.sv
// Directed bench for sc_pack_fifo: three configurations (basic/full, flush,
// show-ahead with MSB-first packing) checked against hand-computed values.
module tb_sc_pack_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // a: RATIO=2, depth 8, normal read
  logic        rst_a, wrreq_a, flush_a, rdreq_a, clr_a;
  logic [7:0]  din_a;
  logic [15:0] dout_a;
  logic        wrfull_a, afull_a, rdempty_a, ovf_a, unf_a;
  logic [3:0]  used_a;
  // b: RATIO=4, depth 32, normal read
  logic        rst_b, wrreq_b, flush_b, rdreq_b, clr_b;
  logic [7:0]  din_b;
  logic [31:0] dout_b;
  logic        wrfull_b, afull_b, rdempty_b, ovf_b, unf_b;
  logic [5:0]  used_b;
  // c: RATIO=2, depth 8, show-ahead, MSB-first
  logic        rst_c, wrreq_c, flush_c, rdreq_c, clr_c;
  logic [7:0]  din_c;
  logic [15:0] dout_c;
  logic        wrfull_c, afull_c, rdempty_c, ovf_c, unf_c;
  logic [3:0]  used_c;

  sc_pack_fifo #(.DATA_IN_W(8), .RATIO(2), .ADDR_W(3), .SHOWAHEAD(0), .AFULL_TH(6), .LSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst_a), .wrreq(wrreq_a), .data_in(din_a), .flush(flush_a), .wrfull(wrfull_a),
    .wr_afull(afull_a), .rdreq(rdreq_a), .data_out(dout_a), .rdempty(rdempty_a), .rdusedw(used_a),
    .overflow(ovf_a), .underflow(unf_a), .clr_err(clr_a));

  sc_pack_fifo #(.DATA_IN_W(8), .RATIO(4), .ADDR_W(5), .SHOWAHEAD(0), .LSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst_b), .wrreq(wrreq_b), .data_in(din_b), .flush(flush_b), .wrfull(wrfull_b),
    .wr_afull(afull_b), .rdreq(rdreq_b), .data_out(dout_b), .rdempty(rdempty_b), .rdusedw(used_b),
    .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_b));

  sc_pack_fifo #(.DATA_IN_W(8), .RATIO(2), .ADDR_W(3), .SHOWAHEAD(1), .AFULL_TH(6), .LSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst_c), .wrreq(wrreq_c), .data_in(din_c), .flush(flush_c), .wrfull(wrfull_c),
    .wr_afull(afull_c), .rdreq(rdreq_c), .data_out(dout_c), .rdempty(rdempty_c), .rdusedw(used_c),
    .overflow(ovf_c), .underflow(unf_c), .clr_err(clr_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick; tick;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    n_chk++; if (rdempty_a !== 1'b1) begin n_fail++; $display("FAIL reset_rdempty_a: got %b want 1", rdempty_a); end
    n_chk++; if (wrfull_a !== 1'b0) begin n_fail++; $display("FAIL reset_wrfull_a: got %b want 0", wrfull_a); end
    n_chk++; if (afull_a !== 1'b0) begin n_fail++; $display("FAIL reset_afull_a: got %b want 0", afull_a); end
    n_chk++; if (used_a !== 4'd0) begin n_fail++; $display("FAIL reset_used_a: got %0d want 0", used_a); end
    n_chk++; if (dout_a !== 16'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h want 0000", dout_a); end
    n_chk++; if (ovf_a !== 1'b0 || unf_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b%b want 00", ovf_a, unf_a); end
    n_chk++; if (rdempty_b !== 1'b1 || wrfull_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got %b%b want 10", rdempty_b, wrfull_b); end
    n_chk++; if (rdempty_c !== 1'b1 || dout_c !== 16'h0) begin n_fail++; $display("FAIL reset_c: got %b %h want 1 0000", rdempty_c, dout_c); end
  endtask

  task automatic test_basic;
    wrreq_a = 1'b1; din_a = 8'h11; tick;
    n_chk++; if (used_a !== 4'd0) begin n_fail++; $display("FAIL basic_partial_used: got %0d want 0", used_a); end
    din_a = 8'h22; tick; wrreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd1) begin n_fail++; $display("FAIL basic_used1: got %0d want 1", used_a); end
    n_chk++; if (rdempty_a !== 1'b0) begin n_fail++; $display("FAIL basic_rdempty: got %b want 0", rdempty_a); end
    rdreq_a = 1'b1; tick; rdreq_a = 1'b0;
    n_chk++; if (dout_a !== 16'h2211) begin n_fail++; $display("FAIL basic_dout: got %h want 2211", dout_a); end
    n_chk++; if (used_a !== 4'd0 || rdempty_a !== 1'b1) begin n_fail++; $display("FAIL basic_used0: got %0d/%b want 0/1", used_a, rdempty_a); end
    tick;
    n_chk++; if (dout_a !== 16'h2211) begin n_fail++; $display("FAIL basic_hold: got %h want 2211", dout_a); end
    // push and pop on the same edge keep the count
    wrreq_a = 1'b1; din_a = 8'h33; tick; din_a = 8'h44; tick; din_a = 8'h55; tick;
    din_a = 8'h66; rdreq_a = 1'b1; tick; wrreq_a = 1'b0; rdreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd1) begin n_fail++; $display("FAIL simul_used: got %0d want 1", used_a); end
    n_chk++; if (dout_a !== 16'h4433) begin n_fail++; $display("FAIL simul_dout: got %h want 4433", dout_a); end
    rdreq_a = 1'b1; tick; rdreq_a = 1'b0;
    n_chk++; if (dout_a !== 16'h6655 || used_a !== 4'd0) begin n_fail++; $display("FAIL simul_dout2: got %h/%0d want 6655/0", dout_a, used_a); end
  endtask

  task automatic test_full;
    logic [15:0] exp;
    wrreq_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_a = 8'(i); tick;
      if (i % 2 == 1) begin
        n_chk++; if (used_a !== 4'((i+1)/2)) begin n_fail++; $display("FAIL fill_used_%0d: got %0d want %0d", i, used_a, (i+1)/2); end
        n_chk++; if (afull_a !== ((i+1)/2 >= 6)) begin n_fail++; $display("FAIL fill_afull_%0d: got %b want %b", i, afull_a, ((i+1)/2 >= 6)); end
      end
    end
    n_chk++; if (wrfull_a !== 1'b1) begin n_fail++; $display("FAIL full_wrfull: got %b want 1", wrfull_a); end
    din_a = 8'hEE; tick;
    n_chk++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", ovf_a); end
    n_chk++; if (used_a !== 4'd8) begin n_fail++; $display("FAIL full_used8: got %0d want 8", used_a); end
    // pop while full: the same-cycle lane is refused
    din_a = 8'hDD; rdreq_a = 1'b1; tick; wrreq_a = 1'b0; rdreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd7 || wrfull_a !== 1'b0) begin n_fail++; $display("FAIL full_pop: got %0d/%b want 7/0", used_a, wrfull_a); end
    n_chk++; if (dout_a !== 16'h0100) begin n_fail++; $display("FAIL full_dout0: got %h want 0100", dout_a); end
    wrreq_a = 1'b1; din_a = 8'hF0; tick; din_a = 8'hF1; tick; wrreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd8 || wrfull_a !== 1'b1) begin n_fail++; $display("FAIL refill: got %0d/%b want 8/1", used_a, wrfull_a); end
    rdreq_a = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick;
      exp = {8'(2*k+1), 8'(2*k)};
      n_chk++; if (dout_a !== exp) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", k, dout_a, exp); end
    end
    tick; rdreq_a = 1'b0;
    n_chk++; if (dout_a !== 16'hF1F0) begin n_fail++; $display("FAIL drain_last: got %h want f1f0", dout_a); end
    n_chk++; if (rdempty_a !== 1'b1 || used_a !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got %b/%0d want 1/0", rdempty_a, used_a); end
  endtask

  task automatic test_underflow;
    clr_a = 1'b1; tick; clr_a = 1'b0;
    n_chk++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", ovf_a); end
    rdreq_a = 1'b1; tick; rdreq_a = 1'b0;
    n_chk++; if (unf_a !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b want 1", unf_a); end
    n_chk++; if (used_a !== 4'd0 || rdempty_a !== 1'b1) begin n_fail++; $display("FAIL underflow_state: got %0d/%b want 0/1", used_a, rdempty_a); end
    n_chk++; if (dout_a !== 16'hF1F0) begin n_fail++; $display("FAIL underflow_dout: got %h want f1f0", dout_a); end
    rdreq_a = 1'b1; clr_a = 1'b1; tick; rdreq_a = 1'b0; clr_a = 1'b0;
    n_chk++; if (unf_a !== 1'b0) begin n_fail++; $display("FAIL clr_priority: got %b want 0", unf_a); end
    wrreq_a = 1'b1; din_a = 8'hAA; tick; din_a = 8'hBB; tick; wrreq_a = 1'b0;
    rdreq_a = 1'b1; tick; rdreq_a = 1'b0;
    n_chk++; if (dout_a !== 16'hBBAA || used_a !== 4'd0) begin n_fail++; $display("FAIL underflow_ptrs: got %h/%0d want bbaa/0", dout_a, used_a); end
  endtask

  task automatic test_reset_mid;
    wrreq_a = 1'b1;
    for (int i = 0; i < 11; i++) begin din_a = 8'h30 + 8'(i); tick; end
    wrreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd5) begin n_fail++; $display("FAIL midrst_pre_used: got %0d want 5", used_a); end
    rst_a = 1'b1; tick; rst_a = 1'b0;
    n_chk++; if (rdempty_a !== 1'b1 || used_a !== 4'd0) begin n_fail++; $display("FAIL midrst_state: got %b/%0d want 1/0", rdempty_a, used_a); end
    n_chk++; if (dout_a !== 16'h0) begin n_fail++; $display("FAIL midrst_dout: got %h want 0000", dout_a); end
    wrreq_a = 1'b1; din_a = 8'h55; tick; din_a = 8'h66; tick; wrreq_a = 1'b0;
    n_chk++; if (used_a !== 4'd1) begin n_fail++; $display("FAIL midrst_used1: got %0d want 1", used_a); end
    rdreq_a = 1'b1; tick; rdreq_a = 1'b0;
    n_chk++; if (dout_a !== 16'h6655) begin n_fail++; $display("FAIL midrst_fresh: got %h want 6655", dout_a); end
  endtask

  task automatic test_flush;
    // partial word of three lanes, zero padded
    wrreq_b = 1'b1; din_b = 8'hA1; tick; din_b = 8'hA2; tick; din_b = 8'hA3; tick; wrreq_b = 1'b0;
    n_chk++; if (used_b !== 6'd0 || wrfull_b !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got %0d/%b want 0/0", used_b, wrfull_b); end
    flush_b = 1'b1; tick; flush_b = 1'b0;
    n_chk++; if (wrfull_b !== 1'b1 || used_b !== 6'd0) begin n_fail++; $display("FAIL flush_pend: got %b/%0d want 1/0", wrfull_b, used_b); end
    tick;
    n_chk++; if (wrfull_b !== 1'b0 || used_b !== 6'd1) begin n_fail++; $display("FAIL flush_push: got %b/%0d want 0/1", wrfull_b, used_b); end
    rdreq_b = 1'b1; tick; rdreq_b = 1'b0;
    n_chk++; if (dout_b !== 32'h00A3A2A1) begin n_fail++; $display("FAIL flush_word: got %h want 00a3a2a1", dout_b); end
    // flush on the completing lane: no extra word
    wrreq_b = 1'b1; din_b = 8'hB1; tick; din_b = 8'hB2; tick; din_b = 8'hB3; tick;
    din_b = 8'hB4; flush_b = 1'b1; tick; wrreq_b = 1'b0; flush_b = 1'b0;
    n_chk++; if (used_b !== 6'd1 || wrfull_b !== 1'b1) begin n_fail++; $display("FAIL flush_full_pend: got %0d/%b want 1/1", used_b, wrfull_b); end
    tick;
    n_chk++; if (used_b !== 6'd1 || wrfull_b !== 1'b0) begin n_fail++; $display("FAIL flush_noextra: got %0d/%b want 1/0", used_b, wrfull_b); end
    rdreq_b = 1'b1; tick; rdreq_b = 1'b0;
    n_chk++; if (dout_b !== 32'hB4B3B2B1 || rdempty_b !== 1'b1) begin n_fail++; $display("FAIL flush_full_word: got %h/%b want b4b3b2b1/1", dout_b, rdempty_b); end
    // flush with a coinciding partial lane; a lane offered while pending is refused
    wrreq_b = 1'b1; din_b = 8'hC1; tick; din_b = 8'hC2; flush_b = 1'b1; tick; flush_b = 1'b0;
    din_b = 8'hEE; tick; wrreq_b = 1'b0;
    n_chk++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL flush_refuse_ovf: got %b want 1", ovf_b); end
    n_chk++; if (used_b !== 6'd1 || wrfull_b !== 1'b0) begin n_fail++; $display("FAIL flush_coinc: got %0d/%b want 1/0", used_b, wrfull_b); end
    rdreq_b = 1'b1; tick; rdreq_b = 1'b0;
    n_chk++; if (dout_b !== 32'h0000C2C1) begin n_fail++; $display("FAIL flush_coinc_word: got %h want 0000c2c1", dout_b); end
  endtask

  task automatic test_showahead;
    wrreq_c = 1'b1; din_c = 8'h12; tick; din_c = 8'h34; tick;
    n_chk++; if (rdempty_c !== 1'b1 || used_c !== 4'd1) begin n_fail++; $display("FAIL sa_push1: got %b/%0d want 1/1", rdempty_c, used_c); end
    din_c = 8'h56; tick;
    n_chk++; if (rdempty_c !== 1'b1) begin n_fail++; $display("FAIL sa_lat1: got %b want 1", rdempty_c); end
    din_c = 8'h78; tick;
    n_chk++; if (rdempty_c !== 1'b0 || dout_c !== 16'h1234) begin n_fail++; $display("FAIL sa_head: got %b/%h want 0/1234", rdempty_c, dout_c); end
    din_c = 8'h9A; tick; din_c = 8'hBC; tick; wrreq_c = 1'b0;
    n_chk++; if (used_c !== 4'd3 || dout_c !== 16'h1234) begin n_fail++; $display("FAIL sa_three: got %0d/%h want 3/1234", used_c, dout_c); end
    rdreq_c = 1'b1; tick;
    n_chk++; if (dout_c !== 16'h5678 || used_c !== 4'd2) begin n_fail++; $display("FAIL sa_pop1: got %h/%0d want 5678/2", dout_c, used_c); end
    tick;
    n_chk++; if (dout_c !== 16'h9ABC || used_c !== 4'd1) begin n_fail++; $display("FAIL sa_pop2: got %h/%0d want 9abc/1", dout_c, used_c); end
    tick; rdreq_c = 1'b0;
    n_chk++; if (rdempty_c !== 1'b1 || used_c !== 4'd0) begin n_fail++; $display("FAIL sa_pop3: got %b/%0d want 1/0", rdempty_c, used_c); end
    n_chk++; if (unf_c !== 1'b0) begin n_fail++; $display("FAIL sa_no_underflow: got %b want 0", unf_c); end
  endtask

  initial begin
    rst_a = 1'b1; wrreq_a = 1'b0; flush_a = 1'b0; rdreq_a = 1'b0; clr_a = 1'b0; din_a = '0;
    rst_b = 1'b1; wrreq_b = 1'b0; flush_b = 1'b0; rdreq_b = 1'b0; clr_b = 1'b0; din_b = '0;
    rst_c = 1'b1; wrreq_c = 1'b0; flush_c = 1'b0; rdreq_c = 1'b0; clr_c = 1'b0; din_c = '0;
    test_reset;
    test_basic;
    test_full;
    test_underflow;
    test_reset_mid;
    test_flush;
    test_showahead;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
